// File: rtl/gen_cond_serializer.sv
`default_nettype none
// ============================================================================
// Module      : gen_cond_serializer
// Description : Parallel-to-serial transmitter whose datapath (shift register
//               or hold register + bit-index mux) is chosen at elaboration.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_cond_serializer #(
    parameter int USE_FAST  = 1,
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic           ST_IDLE  = 1'b0;
    localparam logic           ST_SHIFT = 1'b1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    logic          r_state;
    logic          w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_final;
    logic          w_load;
    logic          w_last_nxt;

    always_comb begin
        w_final     = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);
        in_ready    = !rst && ((r_state == ST_IDLE) || w_final);
        w_load      = in_valid && in_ready;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_load) begin
            w_state_nxt = ST_SHIFT;
            w_cnt_nxt   = '0;
        end else if (r_state == ST_SHIFT) begin
            if (w_final) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt   = r_cnt + CW'(1);
            end
        end
        // Both datapaths register the last strobe alongside the bit it tags.
        w_last_nxt = (w_state_nxt == ST_SHIFT) && (w_cnt_nxt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign ser_valid = r_state;
    assign busy      = r_state;

    if (USE_FAST != 0) begin : fast_impl
        logic [WIDTH-1:0] sh;
        logic             bit_q;
        logic             last_q;

        // sh holds only the bits not yet presented; bit_q is the live bit.
        always_ff @(posedge clk) begin
            if (rst) begin
                sh     <= '0;
                bit_q  <= 1'b0;
                last_q <= 1'b0;
            end else begin
                last_q <= w_last_nxt;
                if (w_load) begin
                    if (LSB_FIRST != 0) begin
                        bit_q <= in_data[0];
                        sh    <= in_data >> 1;
                    end else begin
                        bit_q <= in_data[WIDTH-1];
                        sh    <= in_data << 1;
                    end
                end else if (w_state_nxt == ST_SHIFT) begin
                    if (LSB_FIRST != 0) begin
                        bit_q <= sh[0];
                        sh    <= sh >> 1;
                    end else begin
                        bit_q <= sh[WIDTH-1];
                        sh    <= sh << 1;
                    end
                end else begin
                    bit_q <= 1'b0;
                end
            end
        end
    end else begin : slow_impl
        logic [WIDTH-1:0] hold;
        logic             bit_q;
        logic             last_q;
        logic [CW-1:0]    w_idx;
        logic             w_sel;

        always_comb begin
            w_idx = (LSB_FIRST != 0) ? w_cnt_nxt : (CNT_LAST - w_cnt_nxt);
            w_sel = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                if (w_idx == CW'(i)) begin
                    w_sel = hold[i];
                end
            end
        end

        // The first bit bypasses hold, which is only written on this same edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                hold   <= '0;
                bit_q  <= 1'b0;
                last_q <= 1'b0;
            end else begin
                last_q <= w_last_nxt;
                if (w_load) begin
                    hold  <= in_data;
                    bit_q <= in_data[(LSB_FIRST != 0) ? 0 : (WIDTH - 1)];
                end else if (w_state_nxt == ST_SHIFT) begin
                    bit_q <= w_sel;
                end else begin
                    bit_q <= 1'b0;
                end
            end
        end
    end

    if (USE_FAST != 0) begin : g_out_fast
        assign ser_out  = fast_impl.bit_q;
        assign ser_last = fast_impl.last_q;
    end else begin : g_out_slow
        assign ser_out  = slow_impl.bit_q;
        assign ser_last = slow_impl.last_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_gen_cond_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gen_cond_serializer
// Description : Scoreboard bench over fast/slow, LSB/MSB, WIDTH 8/1 builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_cond_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_valid1;
    logic [0:0] in_data1;

    logic rdy_a, so_a, sv_a, sl_a, bz_a;
    logic rdy_b, so_b, sv_b, sl_b, bz_b;
    logic rdy_c, so_c, sv_c, sl_c, bz_c;
    logic rdy_d, so_d, sv_d, sl_d, bz_d;

    int vec    = 0;
    int miscmp = 0;

    // Each entry is {bit, last} for one expected valid cycle.
    logic [1:0] qa[$];
    logic [1:0] qb[$];
    logic [1:0] qc[$];
    logic [1:0] qd[$];

    always #5 clk = ~clk;

    gen_cond_serializer #(.USE_FAST(1), .WIDTH(8), .LSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
        .ser_out(so_a), .ser_valid(sv_a), .ser_last(sl_a), .busy(bz_a));
    gen_cond_serializer #(.USE_FAST(0), .WIDTH(8), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
        .ser_out(so_b), .ser_valid(sv_b), .ser_last(sl_b), .busy(bz_b));
    gen_cond_serializer #(.USE_FAST(1), .WIDTH(1), .LSB_FIRST(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(rdy_c), .in_data(in_data1),
        .ser_out(so_c), .ser_valid(sv_c), .ser_last(sl_c), .busy(bz_c));
    gen_cond_serializer #(.USE_FAST(0), .WIDTH(1), .LSB_FIRST(0)) dut_d (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(rdy_d), .in_data(in_data1),
        .ser_out(so_d), .ser_valid(sv_d), .ser_last(sl_d), .busy(bz_d));

    // Port monitors: {valid, out, last, busy} against the scoreboard each cycle.
    always @(negedge clk) begin
        logic [1:0] e;
        vec++;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            if ({sv_a, so_a, sl_a, bz_a} !== {1'b1, e, 1'b1}) begin
                miscmp++;
                $display("FAIL stream_a t=%0t got v/o/l/b=%b want %b", $time, {sv_a, so_a, sl_a, bz_a}, {1'b1, e, 1'b1});
            end
        end else if ({sv_a, sl_a, bz_a} !== 3'b000) begin
            miscmp++;
            $display("FAIL idle_a t=%0t got v/l/b=%b want 000", $time, {sv_a, sl_a, bz_a});
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        vec++;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            if ({sv_b, so_b, sl_b, bz_b} !== {1'b1, e, 1'b1}) begin
                miscmp++;
                $display("FAIL stream_b t=%0t got v/o/l/b=%b want %b", $time, {sv_b, so_b, sl_b, bz_b}, {1'b1, e, 1'b1});
            end
        end else if ({sv_b, sl_b, bz_b} !== 3'b000) begin
            miscmp++;
            $display("FAIL idle_b t=%0t got v/l/b=%b want 000", $time, {sv_b, sl_b, bz_b});
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        vec++;
        if (qc.size() > 0) begin
            e = qc.pop_front();
            if ({sv_c, so_c, sl_c, bz_c} !== {1'b1, e, 1'b1}) begin
                miscmp++;
                $display("FAIL stream_c t=%0t got v/o/l/b=%b want %b", $time, {sv_c, so_c, sl_c, bz_c}, {1'b1, e, 1'b1});
            end
        end else if ({sv_c, sl_c, bz_c} !== 3'b000) begin
            miscmp++;
            $display("FAIL idle_c t=%0t got v/l/b=%b want 000", $time, {sv_c, sl_c, bz_c});
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        vec++;
        if (qd.size() > 0) begin
            e = qd.pop_front();
            if ({sv_d, so_d, sl_d, bz_d} !== {1'b1, e, 1'b1}) begin
                miscmp++;
                $display("FAIL stream_d t=%0t got v/o/l/b=%b want %b", $time, {sv_d, so_d, sl_d, bz_d}, {1'b1, e, 1'b1});
            end
        end else if ({sv_d, sl_d, bz_d} !== 3'b000) begin
            miscmp++;
            $display("FAIL idle_d t=%0t got v/l/b=%b want 000", $time, {sv_d, sl_d, bz_d});
        end
    end

    task automatic push_word(input logic [7:0] d);
        for (int k = 0; k < 8; k++) begin
            qa.push_back({d[k], k == 7});
            qb.push_back({d[7-k], k == 7});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_valid1 = 1'b0; in_data1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if ({rdy_a, rdy_b, rdy_c, rdy_d} !== 4'b0000) begin
            miscmp++;
            $display("FAIL reset_ready got %b want 0000", {rdy_a, rdy_b, rdy_c, rdy_d});
        end
        vec++;
        if ({so_a, sv_a, sl_a, bz_a, so_b, sv_b, sl_b, bz_b} !== 8'h00) begin
            miscmp++;
            $display("FAIL reset_outs got %b want 00000000", {so_a, sv_a, sl_a, bz_a, so_b, sv_b, sl_b, bz_b});
        end
        vec++;
        if ({so_c, sv_c, sl_c, bz_c, so_d, sv_d, sl_d, bz_d} !== 8'h00) begin
            miscmp++;
            $display("FAIL reset_outs_w1 got %b want 00000000", {so_c, sv_c, sl_c, bz_c, so_d, sv_d, sl_d, bz_d});
        end
        rst = 1'b0;
        #1;
        vec++;
        if ({rdy_a, rdy_b, rdy_c, rdy_d} !== 4'b1111) begin
            miscmp++;
            $display("FAIL release_ready got %b want 1111", {rdy_a, rdy_b, rdy_c, rdy_d});
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'hA5;
        #1;
        vec++;
        if ({rdy_a, rdy_b} !== 2'b11) begin
            miscmp++;
            $display("FAIL single_accept_ready got %b want 11", {rdy_a, rdy_b});
        end
        @(posedge clk);
        #1;
        push_word(8'hA5);
        in_valid = 1'b0; in_data = 8'h00;
        for (int k = 0; k < 8; k++) begin
            #1;
            vec++;
            if ({rdy_a, rdy_b} !== {2{k == 7}}) begin
                miscmp++;
                $display("FAIL single_ready bit%0d got %b want %b", k, {rdy_a, rdy_b}, {2{k == 7}});
            end
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_data = 8'h0F;
        @(posedge clk);
        #1;
        push_word(8'h0F);
        in_data = 8'hF0;
        for (int k = 0; k < 8; k++) begin
            #1;
            vec++;
            if ({rdy_a, rdy_b} !== {2{k == 7}}) begin
                miscmp++;
                $display("FAIL b2b_ready_w0 bit%0d got %b want %b", k, {rdy_a, rdy_b}, {2{k == 7}});
            end
            @(posedge clk);
            #1;
        end
        push_word(8'hF0);
        in_valid = 1'b0; in_data = 8'h55;
        for (int k = 0; k < 8; k++) begin
            #1;
            vec++;
            if ({rdy_a, rdy_b} !== {2{k == 7}}) begin
                miscmp++;
                $display("FAIL b2b_ready_w1 bit%0d got %b want %b", k, {rdy_a, rdy_b}, {2{k == 7}});
            end
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_data = 8'hFF;
        @(posedge clk);
        #1;
        push_word(8'hFF);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Bit 3 is on the wire; reset arrives together with a competing load.
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h01;
        #1;
        vec++;
        if ({rdy_a, rdy_b} !== 2'b00) begin
            miscmp++;
            $display("FAIL midrst_ready got %b want 00", {rdy_a, rdy_b});
        end
        @(posedge clk);
        #1;
        qa.delete();
        qb.delete();
        vec++;
        if ({sv_a, so_a, sl_a, sv_b, so_b, sl_b} !== 6'b000000) begin
            miscmp++;
            $display("FAIL midrst_outs got %b want 000000", {sv_a, so_a, sl_a, sv_b, so_b, sl_b});
        end
        rst = 1'b0;
        #1;
        vec++;
        if ({rdy_a, rdy_b} !== 2'b11) begin
            miscmp++;
            $display("FAIL midrst_release_ready got %b want 11", {rdy_a, rdy_b});
        end
        @(posedge clk);
        #1;
        push_word(8'h01);
        in_valid = 1'b0; in_data = 8'hFF;
        repeat (11) @(posedge clk);
        #1;
    endtask

    task automatic test_width1();
        logic [2:0] pat;
        pat = 3'b101;
        in_valid1 = 1'b1; in_data1 = pat[0];
        for (int i = 0; i < 3; i++) begin
            #1;
            vec++;
            if ({rdy_c, rdy_d} !== 2'b11) begin
                miscmp++;
                $display("FAIL w1_ready step%0d got %b want 11", i, {rdy_c, rdy_d});
            end
            @(posedge clk);
            #1;
            qc.push_back({pat[i], 1'b1});
            qd.push_back({pat[i], 1'b1});
            if (i < 2) in_data1 = pat[i+1];
            else in_valid1 = 1'b0;
        end
        #1;
        vec++;
        if ({rdy_c, rdy_d} !== 2'b11) begin
            miscmp++;
            $display("FAIL w1_ready_final got %b want 11", {rdy_c, rdy_d});
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
`default_nettype wire
